// File: rtl/pll_ctrl.sv
// Power-up, lock supervision and ODIV0 reconfiguration sequencer for the pixel-clock PLL.
// Runs on the PLL reference clock; every PLL pin is driven from a register.
module pll_ctrl #(
    parameter int unsigned PWD_CYCLES   = 16,
    parameter int unsigned RST_CYCLES   = 64,
    parameter int unsigned LOCK_TIMEOUT = 65535,
    parameter int unsigned LOCK_FILTER  = 256,
    parameter int unsigned GATE_CYCLES  = 8,
    parameter int unsigned MAX_RETRY    = 3,
    parameter logic [6:0]  ODIV_DEFAULT = 7'd41
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       pll_lock_i,
    input  logic       cfg_valid_i,
    input  logic [6:0] cfg_odiv_i,
    output logic       cfg_ready_o,
    output logic       pll_pwd_o,
    output logic       pll_reset_o,
    output logic [6:0] pll_odsel0_o,
    output logic       pll_enclk0_o,
    output logic       clk_ok_o,
    output logic       err_o,
    output logic [1:0] retry_cnt_o
);

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned CNT_MAX = max2(max2(max2(PWD_CYCLES, RST_CYCLES),
                                                max2(LOCK_TIMEOUT, LOCK_FILTER)), GATE_CYCLES);
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] PWD_LAST  = CNT_W'(PWD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_CYCLES - 1);
    localparam logic [1:0]       RETRY_LIM = 2'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_PWD, S_RST, S_WAIT, S_STABLE, S_RUN, S_GATE, S_FAULT
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sync_q;
    logic [1:0]       retry_q, retry_d;
    logic [6:0]       odsel_q, odiv_q;
    logic             pwd_q, reset_q, enclk_q, clk_ok_q, err_q;
    logic             lock_s;

    assign lock_s  = sync_q[1];
    assign cnt_d   = cnt_q + 1'b1;
    assign retry_d = retry_q + 2'd1;

    // LOCK comes straight from the PLL analog macro, so it is asynchronous here.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sync_q <= 2'b00;
        else         sync_q <= {sync_q[0], pll_lock_i};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_PWD;
            cnt_q    <= '0;
            retry_q  <= 2'd0;
            odsel_q  <= ODIV_DEFAULT;
            odiv_q   <= 7'd0;
            pwd_q    <= 1'b1;
            reset_q  <= 1'b1;
            enclk_q  <= 1'b0;
            clk_ok_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            case (state_q)
                S_PWD: if (cnt_q == PWD_LAST) begin
                    state_q <= S_RST;
                    cnt_q   <= '0;
                    pwd_q   <= 1'b0;
                end
                S_RST: if (cnt_q == RST_LAST) begin
                    state_q <= S_WAIT;
                    cnt_q   <= '0;
                    reset_q <= 1'b0;
                end
                S_WAIT: begin
                    if (lock_s) begin
                        state_q <= S_STABLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == TO_LAST) begin
                        retry_q <= retry_d;
                        cnt_q   <= '0;
                        pwd_q   <= 1'b1;
                        reset_q <= 1'b1;
                        if (retry_d == RETRY_LIM) begin
                            state_q <= S_FAULT;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= S_PWD;
                        end
                    end
                end
                // Any dropout restarts both the filter and the lock timeout.
                S_STABLE: begin
                    if (!lock_s) begin
                        state_q <= S_WAIT;
                        cnt_q   <= '0;
                    end else if (cnt_q == FILT_LAST) begin
                        state_q  <= S_RUN;
                        cnt_q    <= '0;
                        enclk_q  <= 1'b1;
                        clk_ok_q <= 1'b1;
                        retry_q  <= 2'd0;
                    end
                end
                S_RUN: begin
                    cnt_q <= '0;
                    if (!lock_s) begin
                        state_q  <= S_RST;
                        reset_q  <= 1'b1;
                        enclk_q  <= 1'b0;
                        clk_ok_q <= 1'b0;
                    end else if (cfg_valid_i && (cfg_odiv_i != 7'd0)) begin
                        state_q  <= S_GATE;
                        odiv_q   <= cfg_odiv_i;
                        enclk_q  <= 1'b0;
                        clk_ok_q <= 1'b0;
                    end
                end
                // ODSEL0 only moves once CLKOUT0 has been gated long enough to drain.
                S_GATE: if (cnt_q == GATE_LAST) begin
                    state_q <= S_RST;
                    cnt_q   <= '0;
                    odsel_q <= odiv_q;
                    reset_q <= 1'b1;
                end
                S_FAULT: cnt_q <= '0;
                default: begin
                    state_q <= S_FAULT;
                    cnt_q   <= '0;
                    pwd_q   <= 1'b1;
                    reset_q <= 1'b1;
                    err_q   <= 1'b1;
                end
            endcase
        end
    end

    assign cfg_ready_o  = (state_q == S_RUN) && lock_s;
    assign pll_pwd_o    = pwd_q;
    assign pll_reset_o  = reset_q;
    assign pll_odsel0_o = odsel_q;
    assign pll_enclk0_o = enclk_q;
    assign clk_ok_o     = clk_ok_q;
    assign err_o        = err_q;
    assign retry_cnt_o  = retry_q;

endmodule
